alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 tb/tb_alu_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential 16-bit ALU with register-bank style write port and {Z,N,C,V} flags.
// Latency: 1 cycle for single-cycle ops, 16 cycles for shift-add MUL; done/rw_out follow the result edge.
// Backpressure: busy is high while an op is in flight; start is ignored until the FSM is back in IDLE.
module alu_seq #(
  parameter int MUL_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op_in,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] d_out,
  output logic        rw_out,
  output logic [3:0]  flags_out
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;

  // Operands captured at the start edge; they stay put for the whole operation.
  logic [3:0]  op_r;
  logic [15:0] a_r;
  logic [15:0] b_r;

  // Shift-add multiplier: multiplicand shifts left, multiplier shifts right, one bit per cycle.
  logic [3:0]  cnt;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [31:0] acc_nx;

  // Single-cycle ALU results.
  logic [15:0] res;
  logic        res_c;
  logic        res_v;
  logic        legal;
  logic [16:0] sum17;
  logic [16:0] shl17;
  logic [16:0] shr17;

  logic        take_mul;

  // MUL_EN=0 turns opcode 8 into an ordinary illegal op routed through EXEC.
  assign take_mul = (op_in == OP_MUL) && (MUL_EN != 0);
  assign busy     = (state != IDLE);
  assign acc_nx   = acc + (mplier[0] ? mcand : 32'd0);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = take_mul ? MUL : EXEC;
      EXEC:    state_nx = IDLE;
      MUL:     if (cnt == 4'd15) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Combinational ALU for everything except MUL; opcode 8 only reaches EXEC when MUL is disabled.
  always_comb begin
    res   = 16'h0000;
    res_c = 1'b0;
    res_v = 1'b0;
    legal = 1'b1;
    sum17 = 17'd0;
    shl17 = {1'b0, a_r} << b_r[3:0];
    shr17 = {a_r, 1'b0} >> b_r[3:0];
    case (op_r)
      OP_ADD: begin
        sum17 = {1'b0, a_r} + {1'b0, b_r};
        res   = sum17[15:0];
        res_c = sum17[16];
        res_v = (a_r[15] == b_r[15]) && (sum17[15] != a_r[15]);
      end
      OP_SUB: begin
        // Bit 16 of the 17-bit difference is the unsigned borrow (A < B).
        sum17 = {1'b0, a_r} - {1'b0, b_r};
        res   = sum17[15:0];
        res_c = sum17[16];
        res_v = (a_r[15] != b_r[15]) && (sum17[15] != a_r[15]);
      end
      OP_AND:  res = a_r & b_r;
      OP_OR:   res = a_r | b_r;
      OP_XOR:  res = a_r ^ b_r;
      OP_NOT:  res = ~a_r;
      OP_SHL: begin
        // Extra bit above A catches the last bit shifted out; stays 0 for a zero shift.
        res   = shl17[15:0];
        res_c = shl17[16];
      end
      OP_SHR: begin
        // Extra bit below A catches the last bit shifted out; stays 0 for a zero shift.
        res   = shr17[16:1];
        res_c = shr17[0];
      end
      OP_PASS: res = b_r;
      default: legal = 1'b0;
    endcase
  end

  // Datapath: operand capture, MUL iteration, result/flag registers and the completion pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r      <= 4'd0;
      a_r       <= 16'h0000;
      b_r       <= 16'h0000;
      cnt       <= 4'd0;
      acc       <= 32'd0;
      mcand     <= 32'd0;
      mplier    <= 16'h0000;
      d_out     <= 16'h0000;
      flags_out <= 4'b0000;
      done      <= 1'b0;
      rw_out    <= 1'b0;
    end else begin
      done   <= 1'b0;
      rw_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r   <= op_in;
            a_r    <= a_in;
            b_r    <= b_in;
            cnt    <= 4'd0;
            acc    <= 32'd0;
            mcand  <= {16'h0000, a_in};
            mplier <= b_in;
          end
        end
        EXEC: begin
          done <= 1'b1;
          if (legal) begin
            rw_out    <= 1'b1;
            d_out     <= res;
            flags_out <= {(res == 16'h0000), res[15], res_c, res_v};
          end
        end
        MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            done      <= 1'b1;
            rw_out    <= 1'b1;
            d_out     <= acc_nx[15:0];
            flags_out <= {(acc_nx[15:0] == 16'h0000), acc_nx[15], (acc_nx[31:16] != 16'h0000), 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
// Latency: checks 1-cycle EXEC and 16-cycle MUL completion timing.
// Backpressure: exercises ignored starts while busy and back-to-back starts on done.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start0;
  logic [3:0]  op_in;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy,  done,  rw_out;
  logic [15:0] d_out;
  logic [3:0]  flags_out;
  logic        busy0, done0, rw0;
  logic [15:0] d0;
  logic [3:0]  f0;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_d = 16'h0000;
  logic [3:0]  exp_f = 4'b0000;

  alu_seq #(.MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_in(op_in), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .d_out(d_out), .rw_out(rw_out), .flags_out(flags_out)
  );

  alu_seq #(.MUL_EN(0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .start(start0), .op_in(op_in), .a_in(a_in), .b_in(b_in),
    .busy(busy0), .done(done0), .d_out(d0), .rw_out(rw0), .flags_out(f0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode table.
  function automatic void ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input bit mul_en, output bit legal, output logic [15:0] r,
                                 output logic [3:0] fl);
    longint ua, ub, sa, sb, full, sfull;
    int s;
    bit c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    s  = b[3:0];
    c = 0; v = 0; legal = 1; r = 16'h0000;
    case (op)
      4'd0: begin
        full = ua + ub; r = full[15:0]; c = (full > 65535);
        sfull = sa + sb; v = (sfull > 32767) || (sfull < -32768);
      end
      4'd1: begin
        full = ua - ub; r = full[15:0]; c = (ua < ub);
        sfull = sa - sb; v = (sfull > 32767) || (sfull < -32768);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin full = ua << s; r = full[15:0]; c = (s != 0) && full[16]; end
      4'd7: begin full = ua >> s; r = full[15:0]; c = (s != 0) && (((ua >> (s - 1)) & 1) != 0); end
      4'd8: begin
        if (mul_en) begin full = ua * ub; r = full[15:0]; c = ((full >> 16) != 0); end
        else legal = 0;
      end
      4'd9: r = b;
      default: legal = 0;
    endcase
    fl = {(r == 16'h0000), r[15], c, v};
  endfunction

  // Issue one op on the MUL-enabled DUT from an IDLE cycle; returns in its done cycle.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int poke, input string tag);
    bit legal;
    logic [15:0] r;
    logic [3:0] fl;
    int lat, cyc;
    ref_op(op, a, b, 1'b1, legal, r, fl);
    lat = (op == 4'd8) ? 16 : 1;
    if (legal) begin exp_d = r; exp_f = fl; end
    start = 1'b1; op_in = op; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 40) begin
      if (cyc == poke) begin
        start = 1'b1; op_in = 4'd0; a_in = 16'($urandom); b_in = 16'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (!done) check({tag, ".rw_quiet"}, rw_out, 0);
    end
    check({tag, ".latency"}, cyc, lat);
    check({tag, ".done"}, done, 1);
    check({tag, ".rw"}, rw_out, legal);
    check({tag, ".d"}, d_out, exp_d);
    check({tag, ".flags"}, flags_out, exp_f);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check({tag, ".idle_done"}, done, 0);
      check({tag, ".idle_rw"}, rw_out, 0);
      check({tag, ".idle_busy"}, busy, 0);
    end
  endtask

  initial begin
    logic [15:0] corner [8];
    logic [3:0]  rop;
    logic [15:0] ra, rb;
    corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001, 16'h00FF, 16'h0100};

    // Reset, with start held high to show it is ignored.
    rst_n = 1'b0; start = 1'b1; start0 = 1'b0; op_in = 4'd0; a_in = 16'h0001; b_in = 16'h0001;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.rw", rw_out, 0);
    check("rst.d", d_out, 16'h0000);
    check("rst.flags", flags_out, 4'b0000);
    check("rst.d0", d0, 16'h0000);
    rst_n = 1'b1; start = 1'b0;
    idle(1, "post_rst");

    // Signed overflow on ADD.
    run_op(4'd0, 16'h7FFF, 16'h0001, -1, "add_ovf");
    check("add_ovf.d_const", d_out, 16'h8000);
    check("add_ovf.f_const", flags_out, 4'b0101);
    idle(1, "add_ovf");

    // SUB borrow, then back-to-back SHL started in the done cycle.
    run_op(4'd1, 16'h0000, 16'h0001, -1, "sub_borrow");
    check("sub_borrow.f_const", flags_out, 4'b0110);
    run_op(4'd6, 16'h8001, 16'h0001, -1, "shl_b2b");
    check("shl_b2b.d_const", d_out, 16'h0002);
    check("shl_b2b.c", flags_out[1], 1);
    idle(1, "shl_b2b");

    // MUL with product overflow and an ignored start mid-operation.
    run_op(4'd8, 16'h0100, 16'h0100, 5, "mul_hi");
    check("mul_hi.f_const", flags_out, 4'b1010);
    idle(1, "mul_hi");

    // Illegal opcode leaves result registers alone.
    run_op(4'd9, 16'h0000, 16'h1234, -1, "pass");
    run_op(4'hF, 16'hAAAA, 16'h5555, -1, "illegal");
    check("illegal.d_const", d_out, 16'h1234);
    idle(1, "illegal");

    // Reset during the 5th cycle of MUL.
    start = 1'b1; op_in = 4'd8; a_in = 16'h1234; b_in = 16'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mul_rst.busy_before", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_d = 16'h0000; exp_f = 4'b0000;
    check("mul_rst.busy", busy, 0);
    check("mul_rst.d", d_out, 16'h0000);
    check("mul_rst.flags", flags_out, 4'b0000);
    check("mul_rst.done", done, 0);
    idle(20, "mul_rst");

    // MUL_EN=0: opcode 8 behaves as illegal with single-cycle latency.
    start0 = 1'b1; op_in = 4'd9; a_in = 16'h0000; b_in = 16'h5A5A;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    check("nomul.pass_done", done0, 1);
    check("nomul.pass_d", d0, 16'h5A5A);
    start0 = 1'b1; op_in = 4'd8; a_in = 16'h0003; b_in = 16'h0005;
    @(posedge clk); #1;
    start0 = 1'b0;
    check("nomul.busy", busy0, 1);
    @(posedge clk); #1;
    check("nomul.done", done0, 1);
    check("nomul.rw", rw0, 0);
    check("nomul.d", d0, 16'h5A5A);
    check("nomul.flags", f0, 4'b0000);
    @(posedge clk); #1;
    check("nomul.done_clear", done0, 0);

    // Randomized ops, mixing back-to-back and gapped issue.
    for (int i = 0; i < 250; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : 16'($urandom);
      run_op(rop, ra, rb, (rop == 4'd8) ? $urandom_range(0, 14) : -1, $sformatf("rnd%0d_op%0d", i, rop));
      if ($urandom_range(0, 1) == 1) idle(1, "rnd_gap");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
